// File: rtl/wta_gamma_controller.sv
// Winner-take-all gamma-cycle controller.
// Sequences one gamma cycle of TIME_PERIOD time steps, latches the first
// (lowest-index) spiking neuron, presents the result through a valid/ready
// handshake, and pulses a neuron clear before returning to idle.

`ifndef WTA_TIME_PERIOD
`define WTA_TIME_PERIOD 8
`endif
`ifndef WTA_NEURONS_PER_LAYER
`define WTA_NEURONS_PER_LAYER 4
`endif

module wta_gamma_controller #(
    parameter int TIME_PERIOD = `WTA_TIME_PERIOD,
    parameter int NEURONS     = `WTA_NEURONS_PER_LAYER
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [NEURONS-1:0]             spike_volley,
    input  logic                           res_ready,
    output logic [$clog2(TIME_PERIOD):0]   time_val,
    output logic                           gamma_active,
    output logic                           inhibit,
    output logic                           neuron_clear,
    output logic                           res_valid,
    output logic                           res_spike,
    output logic [$clog2(TIME_PERIOD)-1:0] res_time,
    output logic [$clog2(NEURONS)-1:0]     res_winner,
    output logic [15:0]                    win_count
);

    localparam int TW = $clog2(TIME_PERIOD) + 1;
    localparam int RW = $clog2(TIME_PERIOD);
    localparam int WW = $clog2(NEURONS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [TW-1:0]   time_val_reg;
    logic            inhibit_reg;
    logic            res_spike_reg;
    logic [RW-1:0]   res_time_reg;
    logic [WW-1:0]   res_winner_reg;
    logic [15:0]     win_count_reg;

    logic            last_step;
    logic            any_spike;
    logic [WW-1:0]   first_idx;

    assign last_step = (time_val_reg == TW'(TIME_PERIOD - 1));
    assign any_spike = |spike_volley;

    // Priority encoder: scanning downward leaves the lowest set index.
    always_comb begin
        first_idx = '0;
        for (int i = NEURONS - 1; i >= 0; i--) begin
            if (spike_volley[i]) begin
                first_idx = WW'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic for the gamma-cycle sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (res_ready) state_next = CLEAR;
            CLEAR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Time counter, winner latch and win counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_val_reg   <= '0;
            inhibit_reg    <= 1'b0;
            res_spike_reg  <= 1'b0;
            res_time_reg   <= '0;
            res_winner_reg <= '0;
            win_count_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    time_val_reg <= '0;
                    if (start) begin
                        // Fresh gamma cycle: forget the previous result.
                        inhibit_reg    <= 1'b0;
                        res_spike_reg  <= 1'b0;
                        res_time_reg   <= '0;
                        res_winner_reg <= '0;
                    end
                end
                RUN: begin
                    time_val_reg <= last_step ? '0 : time_val_reg + TW'(1);
                    // Only the first spiking step wins; later ones are masked.
                    if (!inhibit_reg && any_spike) begin
                        inhibit_reg    <= 1'b1;
                        res_spike_reg  <= 1'b1;
                        res_time_reg   <= time_val_reg[RW-1:0];
                        res_winner_reg <= first_idx;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        inhibit_reg <= 1'b0;
                        if (res_spike_reg) begin
                            win_count_reg <= win_count_reg + 16'd1;
                        end
                    end
                end
                default: begin
                    time_val_reg <= '0;
                end
            endcase
        end
    end

    assign time_val     = time_val_reg;
    assign gamma_active = (state_reg == RUN);
    assign res_valid    = (state_reg == DONE);
    assign neuron_clear = (state_reg == CLEAR);
    assign inhibit      = inhibit_reg;
    assign res_spike    = res_spike_reg;
    assign res_time     = res_time_reg;
    assign res_winner   = res_winner_reg;
    assign win_count    = win_count_reg;

endmodule

// File: doc/wta_gamma_controller.md
WTA_GAMMA_CONTROLLER -- requirements
Module: wta_gamma_controller

Interface
REQ-001 SHALL have parameter TIME_PERIOD, default `time_period, meaning gamma-cycle length in clock cycles (>=2).
REQ-002 SHALL have parameter NEURONS, default `neurons_per_layer, meaning number of competing neurons (>=2).
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: start  input  1  request to begin one gamma cycle; sampled only in IDLE.
REQ-007 Port: spike_volley  input  NEURONS  per-neuron spike flags for the current cycle.
REQ-008 Port: res_ready  input  1  consumer accepts the result.
REQ-009 Port: time_val  output  $clog2(TIME_PERIOD)+1  current time step, driven to the neuron array.
REQ-010 Port: gamma_active  output  1  high in every RUN cycle.
REQ-011 Port: inhibit  output  1  winner latched; neurons suppress further firing.
REQ-012 Port: neuron_clear  output  1  one-cycle pulse to reset neuron potentials.
REQ-013 Port: res_valid  output  1  result available.
REQ-014 Port: res_spike  output  1  a winner occurred in this gamma cycle.
REQ-015 Port: res_time  output  $clog2(TIME_PERIOD)  time step of the winning spike.
REQ-016 Port: res_winner  output  $clog2(NEURONS)  index of the winning neuron.
REQ-017 Port: win_count  output  16  count of gamma cycles that produced a winner.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE and CLEAR, all registered.
REQ-019 IDLE: when start=1, the FSM SHALL go to RUN next cycle with time_val=0; otherwise it SHALL stay in IDLE.
REQ-020 RUN: time_val SHALL increment by 1 per cycle, from 0 to TIME_PERIOD-1.
REQ-021 RUN with time_val=TIME_PERIOD-1: the FSM SHALL go to DONE next cycle, so there are exactly TIME_PERIOD RUN cycles.
REQ-022 RUN, no winner latched, spike_volley!=0: on that edge the block SHALL latch res_winner=lowest set index, res_time=time_val[low bits], res_spike=1, inhibit=1.
REQ-023 Once a winner is latched, later spikes in the same gamma cycle SHALL be ignored.
REQ-024 Several bits set in the same cycle SHALL resolve to the lowest index.
REQ-025 A spike in the final RUN cycle (time_val=TIME_PERIOD-1) SHALL be valid and latched.
REQ-026 spike_volley SHALL be ignored in IDLE, DONE and CLEAR.
REQ-027 DONE: res_valid=1; res_spike, res_time and res_winner SHALL be held stable until the cycle in which res_valid and res_ready are both 1.
REQ-028 res_ready=1 on the first DONE cycle SHALL complete the handshake in that cycle, so there is no minimum hold.
REQ-029 On handshake the FSM SHALL go to CLEAR, and win_count SHALL increment if res_spike=1 (wrapping at 2^16).
REQ-030 CLEAR SHALL last exactly one cycle with neuron_clear=1, then go to IDLE; start asserted during CLEAR SHALL be ignored.
REQ-031 On entering RUN, res_spike, res_time, res_winner and inhibit SHALL clear to 0.
REQ-032 In IDLE, DONE and CLEAR, time_val SHALL be 0 and gamma_active SHALL be 0.
REQ-033 inhibit SHALL stay 1 from the latch edge through DONE, and SHALL clear on entry to CLEAR.
REQ-034 With no spikes in the gamma cycle, DONE SHALL present res_spike=0, res_time=0 and res_winner=0.

Reset
REQ-035 Reset asserted SHALL immediately force IDLE and set every output to 0, including win_count.
REQ-036 Reset mid-RUN or mid-DONE SHALL discard the result, with no neuron_clear pulse.
REQ-037 After reset deassertion the first start SHALL be honoured on the first rising edge.

Verification
REQ-038 Bench SHALL cover, with TIME_PERIOD=8 and NEURONS=4: start; spike_volley=4'b0100 at time_val=3 -> res_valid after 8 RUN cycles, res_spike=1, res_time=3, res_winner=2, win_count=1.
REQ-039 Bench SHALL cover: spike_volley=4'b1010 at time_val=0, then 4'b0001 at time_val=1 -> res_winner=1, res_time=0, with the later spike ignored.
REQ-040 Bench SHALL cover: no spikes -> res_spike=0, res_time=0, res_winner=0, win_count unchanged, one neuron_clear pulse.
REQ-041 Bench SHALL cover: spike 4'b1000 at time_val=7 -> res_time=7, res_winner=3.
REQ-042 Bench SHALL cover: res_ready held low for 5 DONE cycles -> result stable for all 5 cycles; then res_ready=1 -> CLEAR for 1 cycle, then IDLE.
REQ-043 Bench SHALL cover: rst_n low at time_val=4 after a latched spike -> all outputs 0 at once, IDLE, no res_valid.
